// File: rtl/bitbakery_serial_pkg.sv
// Shared types and constants for the BitBakery status-frame UART transmitter.
// Used by uart_tx_byte and bitbakery_serial_tx4 (optional macro BITBAKERY_TX_PARITY_EN).
package bitbakery_serial_pkg;

  typedef enum logic [2:0] {
    GAP,
    LOAD,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;

  localparam logic [1:0] TAG_D0 = 2'b00;
  localparam logic [1:0] TAG_D1 = 2'b01;
  localparam logic [1:0] TAG_D2 = 2'b10;
  localparam logic [1:0] TAG_D3 = 2'b11;

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: 8N1 by default, 8E1 when BITBAKERY_TX_PARITY_EN is defined.
// A start request on the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
  import bitbakery_serial_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_CLK_FREQ / DEF_BAUD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = $clog2(BIT_CYCLES);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             tx_next;
  logic             last;
  logic             accept;
`ifdef BITBAKERY_TX_PARITY_EN
  logic             parity;
`endif

  assign last   = (baud_cnt == CNT_W'(BIT_CYCLES - 1));
  assign done   = (state == STOP) && last;
  assign busy   = (state != GAP);
  assign accept = start && ((state == GAP) || done);

  always_comb begin
    state_next = state;
    tx_next    = tx;
    case (state)
      GAP: ;
      START:
        if (last) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      DATA:
        if (last) begin
          if (bit_cnt != 3'd7) begin
            tx_next = shift[1];
          end else begin
`ifdef BITBAKERY_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = parity;
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end
        end
      PARITY:
        if (last) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      STOP:
        if (last) state_next = GAP;
      default: state_next = GAP;
    endcase
    if (accept) begin
      state_next = START;
      tx_next    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= GAP;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state <= state_next;
      tx    <= tx_next;
      if (accept || (state == GAP) || last) baud_cnt <= '0;
      else                                  baud_cnt <= baud_cnt + CNT_W'(1);
      if (accept)                         bit_cnt <= '0;
      else if ((state == DATA) && last)   bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Shift register is loaded on accept and consumed one bit per period
  always_ff @(posedge clock) begin
    if (accept) begin
      shift <= data;
`ifdef BITBAKERY_TX_PARITY_EN
      parity <= ^data;
`endif
    end else if ((state == DATA) && last) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: rtl/bitbakery_serial_tx4.sv
// Free-running burst sequencer streaming the 4-byte status frame D0..D3, then an idle gap.
// Optional even parity per byte via macro BITBAKERY_TX_PARITY_EN (handled in uart_tx_byte).
module bitbakery_serial_tx4
  import bitbakery_serial_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int GAP_BITS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] D0,
  input  logic [7:0] D1,
  input  logic [7:0] D2,
  input  logic [7:0] D3,
  output logic       saida_serial
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
  localparam int GAP_W      = $clog2(GAP_CYCLES);

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       idx;
  logic [1:0]       next_byte;
  logic [31:0]      shadow;
  logic [7:0]       byte_data;
  logic             gap_end;
  logic             start;
  logic             busy;
  logic             done;

  assign gap_end   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign next_byte = idx + 2'd1;
  assign start     = ((state == LOAD) && !busy) ||
                     ((state == DATA) && done && (idx != 2'd3));
  // D0 goes straight to the byte sender in LOAD so the start bit follows with no extra cycle
  assign byte_data = (state == LOAD) ? D0 : shadow[{next_byte, 3'b000} +: 8];

  always_comb begin
    state_next = state;
    case (state)
      GAP:     if (gap_end) state_next = LOAD;
      LOAD:    if (!busy) state_next = DATA;
      DATA:    if (done && (idx == 2'd3)) state_next = GAP;
      default: state_next = GAP;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= GAP;
      gap_cnt <= '0;
      idx     <= '0;
    end else begin
      state <= state_next;
      if ((state == GAP) && !gap_end) gap_cnt <= gap_cnt + GAP_W'(1);
      else                            gap_cnt <= '0;
      if (state == LOAD)                idx <= '0;
      else if ((state == DATA) && done) idx <= idx + 2'd1;
    end
  end

  // Whole frame captured at once so a burst never mixes old and new inputs
  always_ff @(posedge clock) begin
    if (state == LOAD) shadow <= {D3, D2, D1, D0};
  end

  uart_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tx (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data (byte_data),
    .busy (busy),
    .done (done),
    .tx   (saida_serial)
  );

endmodule

// File: tb/tb_bitbakery_serial_tx4.sv
// Bench for bitbakery_serial_tx4: line-level reference model, burst vector table, reset corners.
// Honours BITBAKERY_TX_PARITY_EN when defined for the build.
module tb_bitbakery_serial_tx4;

  localparam int BIT = 434;
  localparam int GAP = 16 * BIT;
`ifdef BITBAKERY_TX_PARITY_EN
  localparam int LV = 11;
`else
  localparam int LV = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] D0, D1, D2, D3;
  logic       saida_serial;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0][7:0] d;
    logic [3:0][7:0] e;
  } vec_t;
  vec_t vecs[3];

  logic levels[$];
  logic [7:0] decoded[4];

  always #5 clock = ~clock;

  bitbakery_serial_tx4 dut (
    .clock       (clock),
    .reset       (reset),
    .D0          (D0),
    .D1          (D1),
    .D2          (D2),
    .D3          (D3),
    .saida_serial(saida_serial)
  );

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic apply(input logic [3:0][7:0] d);
    D0 = d[0];
    D1 = d[1];
    D2 = d[2];
    D3 = d[3];
  endtask

  // Expected line levels for nbytes of a burst: start, 8 data LSB first, [even parity], stop
  function automatic void build_levels(input logic [3:0][7:0] b, input int nbytes);
    levels.delete();
    for (int i = 0; i < nbytes; i++) begin
      levels.push_back(1'b0);
      for (int k = 0; k < 8; k++) levels.push_back(b[i][k]);
`ifdef BITBAKERY_TX_PARITY_EN
      levels.push_back(^b[i]);
`endif
      levels.push_back(1'b1);
    end
  endfunction

  task automatic check_idle(input string name);
    int bad = 0;
    for (int i = 0; i < GAP; i++) begin
      tick();
      if (saida_serial !== 1'b1) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic wait_fall(input string name, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (saida_serial === 1'b0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no start bit within %0d cycles", name, bound);
    end
  endtask

  // Entered on the first cycle of level 0; leaves on the last cycle of the final level
  task automatic check_levels(input string tag, input logic [3:0][7:0] exp, input int nbytes);
    logic s_start, s_end;
    build_levels(exp, nbytes);
    for (int j = 0; j < levels.size(); j++) begin
      if (j > 0) tick();
      s_start = saida_serial;
      repeat (BIT - 1) tick();
      s_end = saida_serial;
      chk($sformatf("%s_lvl%0d_first", tag, j), int'(s_start), int'(levels[j]));
      chk($sformatf("%s_lvl%0d_last", tag, j), int'(s_end), int'(levels[j]));
      if ((j % LV) >= 1 && (j % LV) <= 8) decoded[j / LV][(j % LV) - 1] = s_end;
    end
    for (int i = 0; i < nbytes; i++)
      chk($sformatf("%s_byte%0d", tag, i), int'(decoded[i]), int'(exp[i]));
  endtask

  initial begin
    int c0, c1, c2, c3;

    vecs[0].d = {8'hC0, 8'h90, 8'h41, 8'h25};
    vecs[1].d = {8'($urandom), 8'($urandom), 8'h7F, 8'($urandom)};
    vecs[1].d[1] = 8'h7F;
    vecs[1].d[0] = 8'($urandom);
    vecs[1].d[2] = 8'($urandom);
    vecs[1].d[3] = 8'($urandom);
    vecs[2].d[0] = 8'($urandom);
    vecs[2].d[1] = 8'($urandom);
    vecs[2].d[2] = 8'($urandom) & 8'hF7;
    vecs[2].d[3] = 8'($urandom);
    for (int i = 0; i < 3; i++) vecs[i].e = vecs[i].d;

    apply(vecs[0].d);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_line_high", int'(saida_serial), 1);
    reset = 1'b0;
    cyc = 0;

    check_idle("initial_gap_idle");
    wait_fall("first_fall", 4, c0);
    chk("first_fall_time", int'(c0 >= GAP && c0 <= GAP + 2), 1);

    c1 = c0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        check_idle($sformatf("gap%0d_idle", i));
        wait_fall($sformatf("burst%0d_fall", i), 4, c1);
        chk("burst_period", c1 - c0, (4 * LV + 16) * BIT + 1);
      end
      // next row's inputs land during byte 0 and must not leak into this burst
      apply(vecs[i + 1].d);
      check_levels($sformatf("b%0d", i), vecs[i].e, 4);
    end

    check_idle("gap2_idle");
    wait_fall("burst2_fall", 4, c2);
    repeat ((2 * LV + 4) * BIT + BIT / 2) tick();
    chk("d2_bit3_on_line", int'(saida_serial), int'(vecs[2].e[2][3]));
    #1 reset = 1'b1;
    #1 chk("reset_async_line", int'(saida_serial), 1);
    repeat (3) @(negedge clock);
    chk("reset_hold_line", int'(saida_serial), 1);
    reset = 1'b0;
    cyc = 0;

    check_idle("post_reset_gap_idle");
    wait_fall("post_reset_fall", 4, c3);
    chk("post_reset_fall_time", c3, GAP + 1);
    check_levels("rst", vecs[2].e, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
